// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: credit-limited in-order fetch into a small queue,
// with redirect flush and discard of responses still in flight.
module instruction_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   fetch_enable,
  output logic                   mem_req_valid,
  output logic [XLEN-1:0]        mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_rsp_valid,
  input  logic [31:0]            mem_rsp_data,
  output logic                   instr_valid,
  output logic [31:0]            instr_data,
  output logic [XLEN-1:0]        instr_pc,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] queue_count
);
  localparam int              AW   = $clog2(DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef struct packed {
    logic [31:0]     data;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, outstanding, discard_cnt;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic            req_pending;
  logic            credit_ok, req_fire, drop, push, pop;

  // Queue slots plus in-flight requests never exceed DEPTH, so a push always fits.
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);

  // Gated by resetn so the combinational fetch_enable path cannot raise a request in reset.
  assign mem_req_valid = resetn && !redirect_valid && (req_pending || (fetch_enable && credit_ok));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign drop        = redirect_valid || (discard_cnt != '0);
  assign push        = mem_rsp_valid && !drop;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign queue_count = count;
  assign instr_data  = instr_valid ? fifo[rd_ptr].data : '0;
  assign instr_pc    = instr_valid ? fifo[rd_ptr].pc   : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      req_pending <= 1'b0;
    end else begin
      // A raised but unaccepted request stays up; redirect forces mem_req_valid low, clearing it.
      req_pending <= mem_req_valid && !mem_req_ready;
      outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc;
        rsp_pc      <= redirect_pc;
        discard_cnt <= outstanding - CW'(mem_rsp_valid);
        count       <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (push) begin
          rsp_pc <= rsp_pc + STEP;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (mem_rsp_valid && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (push) begin
      fifo[wr_ptr] <= '{data: mem_rsp_data, pc: rsp_pc};
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: in-order memory model feeding a scoreboard
// of expected {pc, data}, table-driven flow-control phases, and redirect/reset corners.
module tb_instruction_prefetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b1;
  logic            fetch_enable = 1'b0;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready = 1'b0;
  logic            mem_rsp_valid = 1'b0;
  logic [31:0]     mem_rsp_data = '0;
  logic            instr_valid;
  logic [31:0]     instr_data;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic [$clog2(DEPTH):0] queue_count;

  instruction_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(1)) dut (
    .clk(clk), .resetn(resetn), .fetch_enable(fetch_enable),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ep; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { bit fe; bit rdy; bit ir; int cyc; logic [2:0] exp_cnt; bit exp_rv; int exp_issued; } vec_t;

  int          checks = 0, errors = 0;
  int          epoch = 0, issued = 0;
  logic [31:0] model_fetch = '0;
  bit          rsp_hold = 1'b0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] hold_addr;
  infl_t       inflight[$];
  ent_t        exp_q[$];
  logic [31:0] popped[$];
  vec_t        tbl[5];

  function automatic logic [31:0] img(logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5677;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pop_at(int i);
    return (popped.size() > i) ? popped[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock: sample/check at negedge, then update models and drive the memory response.
  task automatic step();
    bit hs, pop, rv, rsp;
    logic [31:0] a, rpc;
    ent_t  e;
    infl_t f;
    @(negedge clk);
    rv = redirect_valid; rsp = mem_rsp_valid; rpc = redirect_pc;
    if (rv) chk("req_in_redirect", mem_req_valid, 1'b0);
    if (prev_pend && !rv) begin
      chk("req_hold_valid", mem_req_valid, 1'b1);
      chk("req_hold_addr", mem_req_addr, prev_addr);
    end
    if (mem_req_valid) chk("req_addr", mem_req_addr, model_fetch);
    chk("instr_valid", instr_valid, exp_q.size() != 0);
    chk("queue_count", queue_count, exp_q.size());
    hs  = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    pop = instr_valid && instr_ready;
    if (pop) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pop: got pc %0h expected no entry", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_data", instr_data, e.data);
      end
      popped.push_back(instr_pc);
    end
    prev_pend = mem_req_valid && !mem_req_ready && !rv;
    prev_addr = a;
    @(posedge clk); #1;
    if (rsp && inflight.size() != 0) begin
      f = inflight.pop_front();
      if (!rv && f.ep == epoch) exp_q.push_back('{pc: f.addr, data: img(f.addr)});
    end
    if (hs) begin
      inflight.push_back('{addr: a, ep: epoch});
      model_fetch = a + 32'd1;
      issued++;
    end
    if (rv) begin
      epoch++;
      exp_q.delete();
      model_fetch = rpc;
    end
    mem_rsp_valid = !rsp_hold && inflight.size() != 0;
    mem_rsp_data  = mem_rsp_valid ? img(inflight[0].addr) : '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           fe    rdy   ir    cyc cnt   rv    issued
    tbl[0] = '{1'b1, 1'b1, 1'b0, 10, 3'd4, 1'b0, 4};   // backpressure fills exactly DEPTH
    tbl[1] = '{1'b1, 1'b1, 1'b1,  1, 3'd3, 1'b1, 4};   // one pop frees one credit
    tbl[2] = '{1'b1, 1'b1, 1'b0,  5, 3'd4, 1'b0, 5};   // exactly one more request
    tbl[3] = '{1'b1, 1'b1, 1'b1, 20, 3'd2, 1'b1, -1};  // steady streaming
    tbl[4] = '{1'b0, 1'b1, 1'b1,  6, 3'd0, 1'b0, -1};  // drain

    // Asynchronous reset between edges, with fetch_enable already high.
    #1 resetn = 1'b0; fetch_enable = 1'b1;
    #1;
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_queue_count", queue_count, 3'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Streaming fetch from RESET_PC.
    mem_req_ready = 1'b1; instr_ready = 1'b1; popped.delete();
    repeat (12) step();
    for (int i = 0; i < 4; i++) chk("stream_pc", pop_at(i), i);
    fetch_enable = 1'b0;
    repeat (6) step();

    issued = 0;
    foreach (tbl[k]) begin
      fetch_enable = tbl[k].fe; mem_req_ready = tbl[k].rdy; instr_ready = tbl[k].ir;
      repeat (tbl[k].cyc) step();
      chk("tbl_queue_count", queue_count, tbl[k].exp_cnt);
      chk("tbl_req_valid", mem_req_valid, tbl[k].exp_rv);
      if (tbl[k].exp_issued >= 0) chk("tbl_issued", issued, tbl[k].exp_issued);
    end

    // Request hold while memory stalls and fetch_enable toggles.
    instr_ready = 1'b0; mem_req_ready = 1'b0; fetch_enable = 1'b1; #1;
    chk("hold_raise", mem_req_valid, 1'b1);
    hold_addr = mem_req_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      fetch_enable = ~fetch_enable; #1;
      chk("hold_valid", mem_req_valid, 1'b1);
      chk("hold_addr", mem_req_addr, hold_addr);
    end
    mem_req_ready = 1'b1; fetch_enable = 1'b0;
    step();
    chk("hold_release", mem_req_valid, 1'b0);
    instr_ready = 1'b1;
    repeat (5) step();

    // Redirect with three requests in flight.
    rsp_hold = 1'b1; fetch_enable = 1'b1; instr_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0; rsp_hold = 1'b0; instr_ready = 1'b1; popped.delete();
    repeat (12) step();
    chk("redirect_first_pc", pop_at(0), 32'h40);
    chk("redirect_second_pc", pop_at(1), 32'h41);

    // PC wrap through the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0; popped.delete();
    repeat (10) step();
    chk("wrap_pc0", pop_at(0), 32'hFFFF_FFFF);
    chk("wrap_pc1", pop_at(1), 32'h0);

    // Async reset mid-stream, between clock edges.
    repeat (5) step();
    #2 resetn = 1'b0;
    #1;
    chk("midrst_instr_valid", instr_valid, 1'b0);
    chk("midrst_req_valid", mem_req_valid, 1'b0);
    chk("midrst_queue_count", queue_count, 3'd0);
    inflight.delete(); exp_q.delete(); epoch++;
    model_fetch = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; prev_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1; popped.delete();
    repeat (8) step();
    chk("midrst_restart_pc", pop_at(0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_prefetch_unit.md
INSTRUCTION_PREFETCH_UNIT -- requirements
Module: instruction_prefetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, PC and address width.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC after reset.
- PC_STEP, 1, PC increment per instruction (word addressing).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- resetn, in, 1, asynchronous active-low reset.
- fetch_enable, in, 1, permits new memory requests.
- mem_req_valid, out, 1, fetch request valid.
- mem_req_addr, out, XLEN, fetch address.
- mem_req_ready, in, 1, memory accepts request.
- mem_rsp_valid, in, 1, instruction word returned (in order, no backpressure).
- mem_rsp_data, in, 32, instruction word.
- instr_valid, out, 1, queue head valid.
- instr_data, out, 32, head instruction.
- instr_pc, out, XLEN, head PC.
- instr_ready, in, 1, consumer takes head.
- redirect_valid, in, 1, branch/jump redirect, single-cycle pulse.
- redirect_pc, in, XLEN, new fetch PC.
- queue_count, out, $clog2(DEPTH)+1, valid entries in queue.

Function
REQ-003 A request handshake SHALL complete on a cycle where mem_req_valid and mem_req_ready are both 1; a response SHALL be any cycle with mem_rsp_valid=1, consuming exactly one outstanding request.
REQ-004 Counter outstanding (0..DEPTH) SHALL increment on each completed request handshake and decrement on each response; both in one cycle leaves it unchanged.
REQ-005 New request start: mem_req_valid SHALL go high only when fetch_enable=1, redirect_valid=0, and queue_count+outstanding < DEPTH.
REQ-006 Request hold: once raised, mem_req_valid and mem_req_addr SHALL hold until handshake even if fetch_enable drops; only redirect_valid or reset withdraws a request.
REQ-007 mem_req_addr SHALL equal fetch_pc; fetch_pc SHALL advance by PC_STEP (mod 2^XLEN) on each request handshake.
REQ-008 Register rsp_pc SHALL track the PC of the next non-discarded response and advance by PC_STEP per accepted response.
REQ-009 Each non-discarded response SHALL push {mem_rsp_data, rsp_pc} into the FIFO in the same cycle; the entry is visible at the head the next cycle.
REQ-010 Head pop: when instr_valid and instr_ready are both 1, the head SHALL pop.
REQ-011 Simultaneous push and pop SHALL leave queue_count unchanged.
REQ-012 instr_ready while empty SHALL be ignored.
REQ-013 The credit rule in REQ-005 SHALL make overflow impossible.
REQ-014 instr_valid SHALL equal (queue_count != 0); instr_data/instr_pc SHALL come from the head entry with zero added latency.
REQ-015 On redirect_valid=1, the next cycle SHALL have: queue_count=0, instr_valid=0, fetch_pc=redirect_pc, rsp_pc=redirect_pc, any unaccepted request withdrawn.
REQ-016 On redirect, discard_cnt SHALL load outstanding minus that cycle's response (if any); a response arriving in the redirect cycle SHALL be dropped.
REQ-017 While discard_cnt>0, each response SHALL be dropped and decrement discard_cnt; outstanding still decrements.
REQ-018 A redirect while discard_cnt>0 SHALL reload discard_cnt per REQ-016.
REQ-019 A pop in the redirect cycle SHALL still be a valid consumption of the pre-redirect head.
REQ-020 mem_req_valid SHALL be 0 in any cycle redirect_valid=1; requests SHALL resume from redirect_pc the following cycle if REQ-005 holds.

Reset
REQ-021 resetn=0 SHALL immediately clear, regardless of clk:
- fetch_pc=RESET_PC and rsp_pc=RESET_PC;
- outstanding=0, discard_cnt=0, queue_count=0;
- FIFO pointers to 0 and FIFO storage to 0;
- mem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0.
REQ-022 Responses arriving after reset for pre-reset requests are a system error and SHALL NOT be handled; the memory side is reset together.

Verification
REQ-023 Scenario, streaming fetch: reset, fetch_enable=1, mem_req_ready=1, 1-cycle response latency, instr_ready=1 -> instr_pc sequence 0,1,2,3..., with instr_data matching the memory image.
REQ-024 Scenario, backpressure: instr_ready=0, DEPTH=4 -> exactly 4 requests issued, queue_count=4, mem_req_valid=0. Then one pop -> exactly one new request.
REQ-025 Scenario, redirect with in-flight requests: 3 outstanding, redirect_pc=0x40 -> next 3 responses dropped, first instr_pc=0x40, and no stale data is ever presented.
REQ-026 Scenario, request hold: mem_req_ready=0 for 5 cycles while fetch_enable toggles -> mem_req_valid/addr stable until handshake.
REQ-027 Scenario, async reset: resetn low mid-stream, between clock edges -> instr_valid=0 and mem_req_valid=0 immediately; after release, fetch restarts at RESET_PC.
REQ-028 Scenario, PC wrap: redirect_pc=2^XLEN-1 -> next instr_pc values are 2^XLEN-1 then 0.
